// File: rtl/noc_pkg.sv
// Shared mesh-router types: flit format, port indices and allocator state.
package noc_pkg;

  localparam int FLIT_W    = 20;
  localparam int NUM_PORTS = 5;

  localparam int PORT_N     = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_W     = 3;
  localparam int PORT_LOCAL = 4;

  // Flit type lives in the top two bits of every flit.
  typedef enum logic [1:0] {
    HEAD   = 2'b00,
    BODY   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1:FLIT_W-2]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
// Zero latency; no flow control, the caller decides whether the winner is used.
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  win_idx,
  output logic              gnt_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_IN);
      if (!gnt_vld && req[cand]) begin
        gnt_vld       = 1'b1;
        gnt[cand]     = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/out_port_allocator.sv
// Per-output switch allocator with wormhole lock and downstream credit counter.
// Grant is combinational (0-cycle); forwarding stalls while credit_cnt is 0.
module out_port_allocator
  import noc_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] req_tail,
  input  logic [NUM_IN-1:0] req_head,
  input  logic              ci,
  output logic [NUM_IN-1:0] grant,
  output logic              vo,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              locked,
  output logic [2:0]        owner,
  output logic              err
);

  localparam int IDX_W = $clog2(NUM_IN);

  alloc_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             err_q, err_d;

  logic [NUM_IN-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic              credit_ok;

  // Body flits carry no head flag, so they never start a new allocation.
  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req     (req & req_head),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .win_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign credit_ok = (cnt_q != '0);

  always_comb begin
    grant   = '0;
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld && credit_ok) begin
          grant   = arb_gnt;
          rr_d    = arb_idx;
          owner_d = arb_idx;
          if (!req_tail[arb_idx]) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (req[owner_q] && credit_ok) begin
          grant[owner_q] = 1'b1;
          if (req_tail[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered state is already cleared during reset, but req may not be.
    if (!RST) grant = '0;
  end

  assign vo = |grant;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (vo && !ci) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (ci && !vo) begin
      if (cnt_q == CNT_W'(CREDITS)) err_d = 1'b1;
      else                          cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(CREDITS);
      rr_q    <= IDX_W'(NUM_IN - 1);
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign credit_cnt = cnt_q;
  assign locked     = (state_q == LOCKED);
  assign owner      = 3'(owner_q);
  assign err        = err_q;

endmodule

// File: tb/tb_out_port_allocator.sv
// Directed bench for out_port_allocator with a per-cycle reference model.
module tb_out_port_allocator;

  localparam int N  = 5;
  localparam int CR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = '0, req_head = '0, req_tail = '0;
  logic       ci = 1'b0;
  logic [4:0] grant;
  logic       vo;
  logic [2:0] credit_cnt;
  logic       locked;
  logic [2:0] owner;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model state (committed at the clock edge).
  int m_cnt = CR, m_owner = 0, m_ptr = N - 1;
  bit m_locked = 1'b0, m_err = 1'b0;
  int n_cnt = CR, n_owner = 0, n_ptr = N - 1;
  bit n_locked = 1'b0, n_errf = 1'b0;

  out_port_allocator #(.NUM_IN(N), .CREDITS(CR)) dut (
    .clk        (clk),
    .RST        (rst_n),
    .req        (req),
    .req_tail   (req_tail),
    .req_head   (req_head),
    .ci         (ci),
    .grant      (grant),
    .vo         (vo),
    .credit_cnt (credit_cnt),
    .locked     (locked),
    .owner      (owner),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = eligible input with the smallest cyclic distance past the pointer.
  always @(negedge clk) begin : cmp
    int best;
    int bestd;
    int d;
    logic [4:0] eg;
    if (mon_en) begin
      best  = -1;
      bestd = N;
      if (rst_n) begin
        if (!m_locked) begin
          if (m_cnt > 0)
            for (int i = 0; i < N; i++)
              if (req[i] && req_head[i]) begin
                d = (i - m_ptr - 1 + 2 * N) % N;
                if (d < bestd) begin
                  bestd = d;
                  best  = i;
                end
              end
        end else if (req[m_owner] && m_cnt > 0) begin
          best = m_owner;
        end
      end
      eg = (best >= 0) ? 5'(1 << best) : 5'd0;
      chk("mdl.grant", grant, eg);
      chk("mdl.vo", vo, (best >= 0));
      chk("mdl.credit_cnt", credit_cnt, m_cnt);
      chk("mdl.locked", locked, m_locked);
      chk("mdl.owner", owner, m_owner);
      chk("mdl.err", err, m_err);
      n_cnt = m_cnt; n_errf = m_err; n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr;
      if (best >= 0 && !ci) n_cnt = m_cnt - 1;
      else if (best < 0 && ci) begin
        if (m_cnt == CR) n_errf = 1'b1;
        else             n_cnt  = m_cnt + 1;
      end
      if (best >= 0) begin
        if (!m_locked) begin
          n_ptr   = best;
          n_owner = best;
        end
        n_locked = !req_tail[best];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= CR; m_owner <= 0; m_ptr <= N - 1; m_locked <= 1'b0; m_err <= 1'b0;
    end else if (mon_en) begin
      m_cnt <= n_cnt; m_owner <= n_owner; m_ptr <= n_ptr; m_locked <= n_locked; m_err <= n_errf;
    end
  end

  // Called just after a rising edge; drives one cycle and checks it mid-cycle.
  task automatic cyc(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                     input logic c, input logic [4:0] eg, input int ec,
                     input logic el, input string nm);
    req = r; req_head = h; req_tail = t; ci = c;
    @(negedge clk); #1;
    chk({nm, ".grant"}, grant, eg);
    chk({nm, ".cnt"}, credit_cnt, ec);
    chk({nm, ".locked"}, locked, el);
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse(input string nm);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, ".rst_grant"}, grant, 5'd0);
    chk({nm, ".rst_vo"}, vo, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset.cnt", credit_cnt, 3'd4);
    chk("reset.locked", locked, 1'b0);
    chk("reset.err", err, 1'b0);
    chk("reset.owner", owner, 3'd0);

    // Mid-cycle reset with a live request must kill the grant at once.
    req = 5'b00001; req_head = 5'b00001; req_tail = 5'b00001;
    #1 chk("t1.pre_grant", grant, 5'b00001);
    rst_pulse("t1");
    cyc(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 4, 1'b0, "t1.post");
    chk("t1.err", err, 1'b0);

    // Two single-flit requesters alternate until credits run out.
    cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00001, 4, 1'b0, "t2.c1");
    cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00100, 3, 1'b0, "t2.c2");
    cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00001, 2, 1'b0, "t2.c3");
    cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00100, 1, 1'b0, "t2.c4");
    cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, 5'b00000, 0, 1'b0, "t2.c5");

    // Credit at zero: same-cycle ci does not enable a grant.
    cyc(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00000, 0, 1'b0, "t4.ci_at_zero");
    cyc(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1, 1'b0, "t4.grant_after");
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 0, 1'b0, "t4.ret1");
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 1, 1'b0, "t4.ret2");
    cyc(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 2, 1'b0, "t4.grant_ci");
    cyc(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 2, 1'b0, "t4.hold");
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 2, 1'b0, "t4.ret3");
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 3, 1'b0, "t4.ret4");

    // Wormhole: input 1 HEAD/BODY/TAIL holds off input 3's SINGLE.
    cyc(5'b01010, 5'b01010, 5'b01000, 1'b0, 5'b00010, 4, 1'b0, "t3.head");
    cyc(5'b01010, 5'b01000, 5'b01000, 1'b0, 5'b00010, 3, 1'b1, "t3.body");
    cyc(5'b01010, 5'b01000, 5'b01010, 1'b0, 5'b00010, 2, 1'b1, "t3.tail");
    cyc(5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b01000, 1, 1'b0, "t3.next");
    for (int k = 0; k < CR; k++)
      cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, k, 1'b0, "t3.refill");

    // Credit return while full is an overflow; err stays sticky.
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 4, 1'b0, "t5.overflow");
    chk("t5.err_set", err, 1'b1);
    chk("t5.cnt_cap", credit_cnt, 3'd4);
    cyc(5'b10000, 5'b10000, 5'b10000, 1'b0, 5'b10000, 4, 1'b0, "t5.traffic");
    cyc(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 3, 1'b0, "t5.refill");
    chk("t5.err_sticky", err, 1'b1);

    // Reset while locked to input 2.
    cyc(5'b00100, 5'b00100, 5'b00000, 1'b0, 5'b00100, 4, 1'b0, "t6.head");
    cyc(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00000, 3, 1'b1, "t6.locked_ignore");
    chk("t6.owner", owner, 3'd2);
    req = '0; req_head = '0; req_tail = '0;
    rst_pulse("t6");
    chk("t6.cnt", credit_cnt, 3'd4);
    chk("t6.locked", locked, 1'b0);
    chk("t6.err_clr", err, 1'b0);
    cyc(5'b10000, 5'b10000, 5'b10000, 1'b0, 5'b10000, 4, 1'b0, "t6.after_rst");
    cyc(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 3, 1'b0, "t6.idle");

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
